// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the convolution/pooling layer.
//   state_t    - frame sequencer states (IDLE, RUN, DRAIN, DONE)
//   WT_PER_CH  - coefficient words per channel (9 weights + 1 bias)
//   BIAS_IDX   - offset of the bias word inside a channel's coefficient block
//   relu_sat() - clamps a signed value to [0, 2^(dw-1)-1]
package cnn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int WT_PER_CH = 10;
    localparam int BIAS_IDX  = 9;

    // Works at 64 bits so one helper serves any accumulator/output width.
    function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
        return (v < 0) ? 64'sd0 : (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two image-row line buffers plus a 3x3 window register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears buffers and window)
//   in_shift  - accepted pixel strobe; advances buffers and window
//   in_col    - column of the accepted pixel
//   in_data   - accepted pixel
//   out_win   - 3x3 window including the pixel currently on in_data,
//               element k (row-major, top-left = 0) at [k*DATA_W +: DATA_W]
module conv_line_buffer #(
    parameter int IMG_W  = 30,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_shift,
    input  logic [$clog2(IMG_W)-1:0]  in_col,
    input  logic [DATA_W-1:0]         in_data,
    output logic [9*DATA_W-1:0]       out_win
);

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_win [9];
    logic [DATA_W-1:0] w_win [9];

    // New right-hand column: two rows up, one row up, current pixel.
    always_comb begin
        w_win = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win[r*3]   = r_win[r*3+1];
            w_win[r*3+1] = r_win[r*3+2];
        end
        w_win[2] = r_lb0[in_col];
        w_win[5] = r_lb1[in_col];
        w_win[8] = in_data;
    end

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign out_win[k*DATA_W +: DATA_W] = w_win[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (in_shift) begin
            r_lb0[in_col] <= r_lb1[in_col];
            r_lb1[in_col] <= in_data;
            r_win         <= w_win;
        end
    end

endmodule

// File: rtl/conv_pool_layer.sv
// conv_pool_layer: 3x3 convolution + requantise/ReLU (+ optional 2x2 max pool)
// over a raster-order image, NUM_CH output channels computed in parallel.
// Optional feature macro: CONV_POOL_LAYER_POOL_EN (defined = 2x2/stride-2 pooling,
// undefined = every requantised conv value is a result).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start                     - frame start pulse, honoured in IDLE only
//   in_data/in_valid/in_ready - signed pixel stream
//   wt_we/wt_addr/wt_data     - coefficient write (addr = ch*10+k, k=9 is bias), IDLE only
//   out_data/out_valid/out_ready/out_last - result stream, channel c at [c*DATA_W +: DATA_W]
//   busy                      - high outside IDLE
//   frame_done                - one-cycle pulse after the last result transfers
module conv_pool_layer
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 30,
    parameter int IMG_H  = 30,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 6,
    parameter int ACC_W  = 2*DATA_W+8,
    parameter int SHIFT  = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                wt_we,
    input  logic [$clog2(NUM_CH*WT_PER_CH)-1:0] wt_addr,
    input  logic [DATA_W-1:0]                   wt_data,
    output logic [NUM_CH*DATA_W-1:0]            out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NCOEF = NUM_CH*WT_PER_CH;

    state_t r_state, w_next;

    logic [CW-1:0]               r_col;
    logic [RW-1:0]               r_row;
    logic                        w_adv, w_acc_px, w_last_px, w_win_ok;
    logic [9*DATA_W-1:0]         w_win;
    logic signed [DATA_W-1:0]    r_coef [NCOEF];
    logic signed [ACC_W-1:0]     w_sum  [NUM_CH];
    logic signed [ACC_W-1:0]     r_conv [NUM_CH];
    logic                        r_c_valid, r_c_last;
    logic [DATA_W-1:0]           w_rq [NUM_CH];
    logic [DATA_W-1:0]           r_q  [NUM_CH];
    logic                        r_q_valid, r_q_last;
    logic [NUM_CH*DATA_W-1:0]    w_res;
    logic                        w_res_valid, w_res_last;
    logic [NUM_CH*DATA_W-1:0]    r_out;
    logic                        r_out_valid, r_out_last;

    // The whole pipeline freezes while a result waits, so nothing in flight can be lost.
    assign w_adv     = !r_out_valid || out_ready;
    assign w_acc_px  = in_valid && in_ready;
    assign w_last_px = (r_col == CW'(IMG_W-1)) && (r_row == RW'(IMG_H-1));
    assign w_win_ok  = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = (w_acc_px && w_last_px) ? DRAIN : RUN;
            DRAIN:   w_next = (r_out_valid && out_ready && r_out_last) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = r_state != IDLE;
        in_ready   = (r_state == RUN) && w_adv;
        frame_done = r_state == DONE;
    end

    // ---------------- position counters and coefficients ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_acc_px) begin
                r_col <= (r_col == CW'(IMG_W-1)) ? '0 : r_col + CW'(1);
                r_row <= (r_col == CW'(IMG_W-1)) ? r_row + RW'(1) : r_row;
            end
            if (wt_we && r_state == IDLE && 32'(wt_addr) < NCOEF) r_coef[wt_addr] <= wt_data;
        end
    end

    conv_line_buffer #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .in_shift (w_acc_px),
        .in_col   (r_col),
        .in_data  (in_data),
        .out_win  (w_win)
    );

    // ---------------- convolution and requantisation ----------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c] = ACC_W'(r_coef[c*WT_PER_CH+BIAS_IDX]);
            for (int k = 0; k < 9; k++)
                w_sum[c] = w_sum[c] + ACC_W'($signed(w_win[k*DATA_W +: DATA_W])) * ACC_W'(r_coef[c*WT_PER_CH+k]);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            w_rq[c] = DATA_W'(relu_sat(64'(r_conv[c] >>> SHIFT), DATA_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid   <= 1'b0;
            r_c_last    <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_last    <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_conv[c] <= '0;
                r_q[c]    <= '0;
            end
        end else if (w_adv) begin
            r_c_valid   <= w_acc_px && w_win_ok;
            r_c_last    <= w_acc_px && w_last_px;
            r_conv      <= w_sum;
            r_q_valid   <= r_c_valid;
            r_q_last    <= r_c_last;
            r_q         <= w_rq;
            r_out_valid <= w_res_valid;
            r_out_last  <= w_res_valid && w_res_last;
            if (w_res_valid) r_out <= w_res;
        end
    end

`ifdef CONV_POOL_LAYER_POOL_EN
    // ---------------- 2x2 max pool ----------------
    localparam int PW  = (IMG_W-2)/2;
    localparam int PAW = $clog2(PW);

    logic [CW-1:0]     r_c_col, r_q_col;
    logic              r_c_rodd, r_q_rodd;
    logic [DATA_W-1:0] r_hold [NUM_CH];
    logic [DATA_W-1:0] r_pbuf [NUM_CH][PW];
    logic [DATA_W-1:0] w_pair [NUM_CH];
    logic [PAW-1:0]    w_pidx;

    assign w_pidx      = PAW'(r_q_col >> 1);
    assign w_res_valid = r_q_valid && r_q_col[0] && r_q_rodd;
    assign w_res_last  = r_q_last;

    // Horizontal pair max; on odd conv rows also folded with the stored even-row pair.
    always_comb begin
        w_res = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pair[c] = ($signed(r_q[c]) > $signed(r_hold[c])) ? r_q[c] : r_hold[c];
            w_res[c*DATA_W +: DATA_W] = ($signed(r_pbuf[c][w_pidx]) > $signed(w_pair[c])) ? r_pbuf[c][w_pidx] : w_pair[c];
        end
    end

    // Conv row/col are pixel row/col minus 2, so parities carry straight over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_col  <= '0;
            r_q_col  <= '0;
            r_c_rodd <= 1'b0;
            r_q_rodd <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_hold[c] <= '0;
                for (int p = 0; p < PW; p++) r_pbuf[c][p] <= '0;
            end
        end else if (w_adv) begin
            r_c_col  <= r_col - CW'(2);
            r_c_rodd <= r_row[0];
            r_q_col  <= r_c_col;
            r_q_rodd <= r_c_rodd;
            if (r_q_valid && !r_q_col[0]) r_hold <= r_q;
            if (r_q_valid && r_q_col[0] && !r_q_rodd)
                for (int c = 0; c < NUM_CH; c++) r_pbuf[c][w_pidx] <= w_pair[c];
        end
    end
`else
    assign w_res_valid = r_q_valid;
    assign w_res_last  = r_q_last;

    always_comb begin
        w_res = '0;
        for (int c = 0; c < NUM_CH; c++) w_res[c*DATA_W +: DATA_W] = r_q[c];
    end
`endif

    assign out_data  = r_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_pool_layer.sv
// tb_conv_pool_layer: randomized self-checking bench against a frame-level reference model.
module tb_conv_pool_layer;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int NC = 2;
    localparam int SH = 0;
    localparam int AW = $clog2(NC*10);
    localparam int MAXV = (1 << (DW-1)) - 1;
`ifdef CONV_POOL_LAYER_POOL_EN
    localparam int NR = ((W-2)/2)*((H-2)/2);
`else
    localparam int NR = (W-2)*(H-2);
`endif

    logic clk, rst, start;
    logic [DW-1:0] in_data;
    logic in_valid, in_ready;
    logic wt_we;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_data;
    logic [NC*DW-1:0] out_data;
    logic out_valid, out_ready, out_last, busy, frame_done;

    int checks = 0;
    int failures = 0;
    int img [H][W];
    int coef [NC][10];
    logic [NC*DW-1:0] exp_q [$];

    conv_pool_layer #(
        .IMG_W(W), .IMG_H(H), .DATA_W(DW), .NUM_CH(NC), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rq(input int v);
        int s;
        s = v >>> SH;
        return (s < 0) ? 0 : (s > MAXV) ? MAXV : s;
    endfunction

    task automatic build_model();
        int cv [H-2][W-2][NC];
        int s, m;
        logic [NC*DW-1:0] e;
        exp_q.delete();
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++)
                for (int ch = 0; ch < NC; ch++) begin
                    s = coef[ch][9];
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) s += img[r+i][c+j] * coef[ch][i*3+j];
                    cv[r][c][ch] = rq(s);
                end
`ifdef CONV_POOL_LAYER_POOL_EN
        for (int pr = 0; pr < (H-2)/2; pr++)
            for (int pc = 0; pc < (W-2)/2; pc++) begin
                for (int ch = 0; ch < NC; ch++) begin
                    m = 0;
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++)
                            if (cv[2*pr+i][2*pc+j][ch] > m) m = cv[2*pr+i][2*pc+j][ch];
                    e[ch*DW +: DW] = m[DW-1:0];
                end
                exp_q.push_back(e);
            end
`else
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++) begin
                for (int ch = 0; ch < NC; ch++) begin
                    m = cv[r][c][ch];
                    e[ch*DW +: DW] = m[DW-1:0];
                end
                exp_q.push_back(e);
            end
`endif
    endtask

    task automatic load_coefs();
        for (int ch = 0; ch < NC; ch++)
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                wt_we = 1'b1;
                wt_addr = AW'(ch*10+k);
                wt_data = DW'(coef[ch][k]);
            end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    task automatic fill(input int px, input int w0, input int w1, input int b);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = px;
        for (int k = 0; k < 9; k++) begin
            coef[0][k] = w0;
            coef[1][k] = w1;
        end
        coef[0][9] = b;
        coef[1][9] = b;
    endtask

    task automatic fill_rand(input int plo, input int phi, input int wlo, input int whi);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, phi-plo)) + plo;
        for (int ch = 0; ch < NC; ch++)
            for (int k = 0; k < 10; k++) coef[ch][k] = int'($urandom_range(0, whi-wlo)) + wlo;
    endtask

    // Streams one frame; a coefficient write and a start pulse are injected mid-frame
    // and must both be ignored.
    task automatic run_frame(input bit bp, input bit stall_first);
        int pix = 0, got = 0, dones = 0, stall = 0;
        bit seen = 0;
        logic [NC*DW-1:0] held = '0, e;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
            if (stall > 0) begin
                chk("stall_data", out_data, held);
                chk("stall_in_ready", in_ready, 0);
                stall--;
            end
            if (stall_first && !seen && out_valid) begin
                seen = 1;
                held = out_data;
                stall = 5;
            end
            in_valid  = (pix < W*H) && (!bp || $urandom_range(0, 3) != 0);
            in_data   = in_valid ? DW'(img[pix/W][pix%W]) : DW'($urandom);
            out_ready = (stall > 0) ? 1'b0 : (!bp || $urandom_range(0, 2) != 0);
            wt_we     = (cyc == 10);
            wt_addr   = AW'(9);
            wt_data   = DW'(50);
            start     = (cyc == 12);
            #1;
            if (in_valid && in_ready) pix++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_result", got, NR - 1);
                else begin
                    e = exp_q.pop_front();
                    chk("result_data", out_data, e);
                    chk("result_last", out_last, exp_q.size() == 0);
                end
                got++;
            end
            if (frame_done) dones++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wt_we = 1'b0;
        start = 1'b0;
        chk("result_count", got, NR);
        chk("pixel_count", pix, W*H);
        chk("frame_done_count", dones, 1);
        chk("idle_busy", busy, 0);
        chk("idle_frame_done", frame_done, 0);
    endtask

    task automatic abort_frame(input int npix);
        int pix = 0, lasts = 0, dones = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && pix < npix; cyc++) begin
            in_valid = 1'b1;
            in_data = DW'(img[pix/W][pix%W]);
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) pix++;
            if (out_last) lasts++;
            if (frame_done) dones++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_pixels", pix, npix);
        chk("abort_out_last", lasts, 0);
        chk("abort_frame_done", dones, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_data", out_data, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        wt_we = 1'b0;
        wt_addr = '0;
        wt_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        fill(1, 1, 1, 0);
        load_coefs();
        run_frame(0, 0);

        fill(1, 1, -1, 0);
        load_coefs();
        run_frame(0, 0);

        fill(127, 127, 127, 127);
        load_coefs();
        run_frame(1, 0);

        fill(1, 1, 1, 0);
        load_coefs();
        run_frame(0, 1);

        abort_frame(20);
        fill(1, 0, 0, 0);
        run_frame(0, 0);
        fill(1, 1, 1, 0);
        load_coefs();
        run_frame(0, 0);

        fill_rand(-8, 8, -4, 4);
        load_coefs();
        run_frame(1, 0);
        fill_rand(0, 3, -2, 2);
        load_coefs();
        run_frame(1, 1);
        fill_rand(-128, 127, -128, 127);
        load_coefs();
        run_frame(1, 0);
        fill_rand(-20, 20, -3, 3);
        load_coefs();
        run_frame(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
